fir_decimator: RTL and testbench
================================

# fir_decimator

Downstream stage of the FIR filter. Takes the filter's Q1.15 output stream, integrates `2**LOG2_DEC` consecutive valid samples, and dumps their rounded mean. The mean goes into a small show-ahead FIFO with a valid/ready output handshake. The FIR is free-running, so the input side has no back-pressure; FIFO overflow is flagged, never stalled.

## Interface
- `WIDTH`, 16: sample width, signed Q1.15 in and out.
- `LOG2_DEC`, 2: log2 of decimation factor D (D = 4); legal range 0..4.
- `LOG2_DEPTH`, 2: log2 of FIFO depth (4 entries).

- `CLK`  in  1  sole clock; all state changes on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `x_in`  in  WIDTH  FIR output sample `y`, Q1.15.
- `in_valid`  in  1  `x_in` is a new sample this cycle.
- `frame_sync`  in  1  qualified by `in_valid`; this sample starts a new block.
- `dec_out`  out  WIDTH  FIFO head, Q1.15.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `fifo_count`  out  LOG2_DEPTH+1  current occupancy.
- `overflow`  out  1  sticky; a dump was dropped because the FIFO was full.

## Operation
- State:
  - `phase` counter, 0..D-1.
  - `acc`, signed, WIDTH+LOG2_DEC bits.
  - FIFO storage plus read/write pointers.
- Accepted sample: `in_valid`=1.
  - phase≠D-1: `acc <= acc + x_in` (sign-extended); phase increments.
  - phase=D-1 (dump):
    - `sum = acc + x_in`.
    - `mean = (sum + 2**(LOG2_DEC-1)) >>> LOG2_DEC`: arithmetic shift, round half toward +inf.
    - Push `mean[WIDTH-1:0]` into the FIFO; `acc <= 0`; `phase <= 0`.
  - LOG2_DEC=0: no rounding term; every sample is a dump (pass-through).
- No saturation logic. The mean of D in-range values plus rounding always lies within [0x8000, 0x7FFF], so truncation to WIDTH is exact.
- `frame_sync`=1 with `in_valid`: discard the partial sum. The sample becomes sample 0 of a new block (`acc <= x_in`, `phase <= 1`). No dump, even if phase was D-1. With D=1 it still dumps.
- FIFO, show-ahead:
  - `dec_out` = head entry.
  - Pop when `out_valid && out_ready`.
- Push while full:
  - With a pop in the same cycle: the push succeeds and the count is unchanged.
  - Without a pop: the value is dropped, `overflow <= 1`, and the accumulator still restarts.
- Pop while empty: ignored.
- `overflow` clears only on `RST`.

## Timing
- Reset values:
  - `phase`=0, `acc`=0, pointers=0, all FIFO entries=0.
  - `dec_out`=0x0000, `out_valid`=0, `fifo_count`=0, `overflow`=0.
- `RST` mid-block: the partial sum is lost and the FIFO is emptied. `RST` overrides every other input in that cycle.
- Latency: `out_valid` rises, and `dec_out` shows the mean, on the edge that accepts the final (D-th) sample. The consumer sees it in the following cycle.
- Throughput: one dump per D accepted samples; one pop per cycle max.
- `dec_out` and `out_valid` are registered or driven directly from registers. No combinational path from `out_ready` to `out_valid`.
- `fifo_count` updates on the same edge as the push/pop it reflects.

## Structure
- Shared package `dsp_pkg`:
  - `Q15_MAX` = 16'h7FFF, `Q15_MIN` = 16'h8000.
  - Q1.15 sample typedef.
  - Accumulator-width function `WIDTH+LOG2_DEC`.
- Sub-module `sync_fifo_sa`: parameterised show-ahead synchronous FIFO with count and full/empty. It is reusable by later stages.
- Top level: phase counter, accumulator, round/shift, overflow flag, FIFO instance.

## Test plan
Defaults: D=4, depth 4, `out_ready`=1 unless stated.
- 4× 0x4000 → `dec_out`=0x4000, `out_valid` high from the edge accepting the 4th sample; `fifo_count` 1 → 0 after pop.
- 4× 0x7FFF → 0x7FFF; 4× 0x8000 → 0x8000. No wrap.
- Rounding, samples (s,0,0,0):
  - s=0x0001 → 0x0000
  - s=0x0002 → 0x0001
  - s=0xFFFE → 0x0000
  - s=0xFFFD → 0xFFFF
- `out_ready`=0, 20 samples (blocks of value 1..5 each) → 4 entries held, 5th dropped, `overflow`=1. Then `out_ready`=1 → 1, 2, 3, 4 in order, `out_valid` falls, `overflow` stays 1.
- 2× 0x1000, then `frame_sync` with 0x2000 plus 3× 0x2000 → single output 0x2000. The earlier partial sum contributes nothing.
- `RST` after 3 samples with 2 FIFO entries pending → all outputs at reset values next cycle. The next 4× 0x0800 → 0x0800.

Source files
------------

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared Q1.15 constants, sample type and accumulator sizing
package dsp_pkg;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    typedef logic signed [15:0] q15_t;

    function automatic int acc_width(input int width, input int log2_dec);
        return width + log2_dec;
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// rtl/sync_fifo_sa.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo_sa #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [LOG2_DEPTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full   = (r_count == (LOG2_DEPTH+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - integrate-and-dump decimator with rounded mean into a show-ahead FIFO
module fir_decimator
    import dsp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEC   = 2,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      x_in,
    input  logic                  in_valid,
    input  logic                  frame_sync,
    output logic [WIDTH-1:0]      dec_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LOG2_DEPTH:0]   fifo_count,
    output logic                  overflow
);

    localparam int DEC     = 1 << LOG2_DEC;
    localparam int ACC_W   = acc_width(WIDTH, LOG2_DEC);
    localparam int PHASE_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;

    localparam logic signed [ACC_W-1:0] ROUND      = ACC_W'(DEC >> 1);
    localparam logic [PHASE_W-1:0]      LAST_PHASE = PHASE_W'(DEC - 1);

    logic [PHASE_W-1:0]      r_phase;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_overflow;

    logic signed [ACC_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0] w_acc_base;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_sum_rnd;
    logic [WIDTH-1:0]        w_mean;
    logic                    w_dump;
    logic                    w_full;
    logic                    w_empty;

    assign w_x_ext    = ACC_W'($signed(x_in));
    // frame_sync throws away the partial sum, so the new block starts from zero.
    assign w_acc_base = frame_sync ? '0 : r_acc;
    assign w_sum      = w_acc_base + w_x_ext;
    assign w_sum_rnd  = w_sum + ROUND;
    assign w_mean     = WIDTH'(w_sum_rnd >>> LOG2_DEC);

    assign w_dump = in_valid && (frame_sync ? (DEC == 1) : (r_phase == LAST_PHASE));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_phase    <= '0;
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (in_valid) begin
            if (w_dump) begin
                r_phase <= '0;
                r_acc   <= '0;
                if (w_full && !out_ready) begin
                    r_overflow <= 1'b1;
                end
            end else begin
                r_acc   <= w_sum;
                r_phase <= frame_sync ? PHASE_W'(1) : r_phase + PHASE_W'(1);
            end
        end
    end

    sync_fifo_sa #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst         (RST),
        .i_push      (w_dump),
        .i_push_data (w_mean),
        .i_pop       (out_ready),
        .o_head      (dec_out),
        .o_count     (fifo_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - self-checking bench for fir_decimator
module tb_fir_decimator;
    import dsp_pkg::*;

    localparam int WIDTH      = 16;
    localparam int LOG2_DEC   = 2;
    localparam int LOG2_DEPTH = 2;
    localparam int D          = 4;
    localparam int DEPTH      = 4;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [WIDTH-1:0]    x_in = '0;
    logic                in_valid = 1'b0;
    logic                frame_sync = 1'b0;
    logic [WIDTH-1:0]    dec_out;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [LOG2_DEPTH:0] fifo_count;
    logic                overflow;

    int errors = 0;
    int checks = 0;

    int         blk[$];
    logic [15:0] mq[$];
    bit         m_ovf;

    fir_decimator #(
        .WIDTH      (WIDTH),
        .LOG2_DEC   (LOG2_DEC),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .x_in       (x_in),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .dec_out    (dec_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] ref_mean(input int s);
        int n;
        int q;
        n = s + D / 2;
        q = n / D;
        if ((n % D) != 0 && n < 0) q = q - 1;
        return q[15:0];
    endfunction

    task automatic model_step(input logic [15:0] x, input logic v, input logic fs, input logic rdy);
        bit          pop_ok;
        bit          dump;
        int          sum;
        logic [15:0] m;
        pop_ok = rdy && (mq.size() > 0);
        dump   = 0;
        m      = '0;
        if (v) begin
            if (fs) blk.delete();
            blk.push_back(int'($signed(x)));
            if (blk.size() == D) begin
                sum = 0;
                foreach (blk[i]) sum += blk[i];
                m = ref_mean(sum);
                blk.delete();
                dump = 1;
            end
        end
        if (dump && mq.size() == DEPTH && !pop_ok) m_ovf = 1;
        if (pop_ok) void'(mq.pop_front());
        if (dump && mq.size() < DEPTH) mq.push_back(m);
    endtask

    task automatic cyc(input logic [15:0] x, input logic v, input logic fs, input logic rdy);
        x_in       = x;
        in_valid   = v;
        frame_sync = fs;
        out_ready  = rdy;
        @(posedge CLK);
        #1;
        model_step(x, v, fs, rdy);
        in_valid   = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        out_ready  = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        blk.delete();
        mq.delete();
        m_ovf = 0;
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        x_in     = 16'h7FFF;
        in_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        in_valid = 1'b0;
        RST      = 1'b0;
        checks++; if (dec_out !== 16'h0000) begin errors++; $display("FAIL reset_dec_out: got %h expected 0000", dec_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(16'h4000, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        cyc(16'h4000, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (dec_out !== 16'h4000) begin errors++; $display("FAIL basic_dec_out: got %h expected 4000", dec_out); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", fifo_count); end
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d expected 0", fifo_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall: got %b expected 0", out_valid); end
    endtask

    task automatic test_extremes();
        logic [15:0] vals [2];
        vals[0] = Q15_MAX;
        vals[1] = Q15_MIN;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < D; i++) cyc(vals[k], 1'b1, 1'b0, 1'b0);
            checks++; if (dec_out !== vals[k]) begin errors++; $display("FAIL extreme_%0d: got %h expected %h", k, dec_out, vals[k]); end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] s   [4];
        logic [15:0] exp [4];
        s[0] = 16'h0001; exp[0] = 16'h0000;
        s[1] = 16'h0002; exp[1] = 16'h0001;
        s[2] = 16'hFFFE; exp[2] = 16'h0000;
        s[3] = 16'hFFFD; exp[3] = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            cyc(s[k], 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < D - 1; i++) cyc(16'h0000, 1'b1, 1'b0, 1'b0);
            checks++; if (dec_out !== exp[k]) begin errors++; $display("FAIL round_%h: got %h expected %h", s[k], dec_out, exp[k]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int b = 1; b <= 5; b++)
            for (int i = 0; i < D; i++) cyc(16'(b), 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (dec_out !== 16'(k)) begin errors++; $display("FAIL ovf_drain_%0d: got %h expected %h", k, dec_out, 16'(k)); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_%0d: got %b expected 1", k, out_valid); end
            cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_frame_sync();
        do_reset();
        cyc(16'h1000, 1'b1, 1'b0, 1'b0);
        cyc(16'h1000, 1'b1, 1'b0, 1'b0);
        cyc(16'h2000, 1'b1, 1'b1, 1'b0);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL fs_no_dump: got %0d expected 0", fifo_count); end
        for (int i = 0; i < 3; i++) cyc(16'h2000, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL fs_count: got %0d expected 1", fifo_count); end
        checks++; if (dec_out !== 16'h2000) begin errors++; $display("FAIL fs_value: got %h expected 2000", dec_out); end
        for (int i = 0; i < 3; i++) cyc(16'h0400, 1'b1, 1'b0, 1'b0);
        cyc(16'h0100, 1'b1, 1'b1, 1'b0);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL fs_last_phase: got %0d expected 1", fifo_count); end
        for (int i = 0; i < 3; i++) cyc(16'h0100, 1'b1, 1'b0, 1'b1);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL fs_pop_push: got %0d expected 1", fifo_count); end
        checks++; if (dec_out !== 16'h0100) begin errors++; $display("FAIL fs_second: got %h expected 0100", dec_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2 * D + 3; i++) cyc(16'h0100, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_mid_pending: got %0d expected 2", fifo_count); end
        RST = 1'b1;
        cyc(16'h7FFF, 1'b1, 1'b1, 1'b1);
        RST = 1'b0;
        blk.delete();
        mq.delete();
        m_ovf = 0;
        checks++; if (dec_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_dec_out: got %h expected 0000", dec_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < D; i++) cyc(16'h0800, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rst_mid_after_count: got %0d expected 1", fifo_count); end
        checks++; if (dec_out !== 16'h0800) begin errors++; $display("FAIL rst_mid_after_value: got %h expected 0800", dec_out); end
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic        v;
        logic        fs;
        logic        rdy;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            x   = 16'($urandom);
            v   = ($urandom_range(0, 3) != 0);
            fs  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            cyc(x, v, fs, rdy);
            checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, mq.size() > 0); end
            checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, fifo_count, mq.size()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow[%0d]: got %b expected %b", n, overflow, m_ovf); end
            if (mq.size() > 0) begin
                checks++; if (dec_out !== mq[0]) begin errors++; $display("FAIL rand_dec_out[%0d]: got %h expected %h", n, dec_out, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_rounding();
        test_overflow();
        test_frame_sync();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
